fir_mac_stream_out: RTL and testbench

//   Downstream stage of the FIR address generator. Multiply-accumulates one tap x data pair per mac_en pulse.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_mac_stream_out_if.sv | 12 +
 rtl/fir_out_fifo.sv | 50 +++++
 rtl/fir_mac_stream_out.sv | 139 +++++++++++++
 tb/tb_fir_mac_stream_out.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared widths, saturation bounds and FIFO entry type for the FIR output stage.
package fir_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int LEN_WIDTH  = 10;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/fir_mac_stream_out_if.sv
// AXI-Stream result port of the FIR output stage.
interface fir_mac_stream_out_if #(
  parameter int DW = 32
);
  logic          sm_tvalid;
  logic          sm_tready;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;

  modport master (output sm_tvalid, output sm_tdata, output sm_tlast, input sm_tready);
  modport slave  (input sm_tvalid, input sm_tdata, input sm_tlast, output sm_tready);
endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous result FIFO; exposes the head and the entry behind it for the output register.
module fir_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         next_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];
  assign next_o  = mem_q[rd_q + 1'b1];

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fir_mac_stream_out.sv
// FIR MAC + result FIFO + AXI-Stream master with frame tlast.
// Optional FIR_SATURATE_EN: clamp each accumulate instead of wrapping.
module fir_mac_stream_out import fir_pkg::*; #(
  parameter int pDATA_WIDTH = DATA_WIDTH,
  parameter int pFIFO_DEPTH = 2,
  parameter int pLEN_WIDTH  = LEN_WIDTH
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   mac_reset,
  input  logic                   mac_en,
  input  logic [pDATA_WIDTH-1:0] tap_do,
  input  logic [pDATA_WIDTH-1:0] data_do,
  input  logic                   result_ready,
  input  logic [pLEN_WIDTH-1:0]  data_length,
  output logic                   res_full,
  fir_mac_stream_out_if.master   sm,
  output logic                   frame_done,
  output logic                   ovf_err
);
  localparam int CW = $clog2(pFIFO_DEPTH) + 1;

  logic [pDATA_WIDTH-1:0] acc_q, acc_d, mac_sum;
  logic [pDATA_WIDTH-1:0] head, next_entry;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;

  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [pDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [pLEN_WIDTH-1:0]  cnt_q, cnt_d, len_q, len_d, last_idx;
  logic                   frame_done_q, ovf_q;
  logic                   hs, push, ovf_set;

`ifdef FIR_SATURATE_EN
  localparam int W2 = 2 * pDATA_WIDTH;
  localparam logic signed [W2-1:0] SAT_HI2 = {{(pDATA_WIDTH+1){1'b0}}, {(pDATA_WIDTH-1){1'b1}}};
  localparam logic signed [W2-1:0] SAT_LO2 = {{(pDATA_WIDTH+1){1'b1}}, {(pDATA_WIDTH-1){1'b0}}};
  logic signed [W2-1:0] prod_w, sum_w;

  always_comb begin
    prod_w = $signed({{pDATA_WIDTH{tap_do[pDATA_WIDTH-1]}}, tap_do})
           * $signed({{pDATA_WIDTH{data_do[pDATA_WIDTH-1]}}, data_do});
    sum_w  = $signed({{pDATA_WIDTH{acc_q[pDATA_WIDTH-1]}}, acc_q}) + prod_w;
    if (sum_w > SAT_HI2)      mac_sum = SAT_HI2[pDATA_WIDTH-1:0];
    else if (sum_w < SAT_LO2) mac_sum = SAT_LO2[pDATA_WIDTH-1:0];
    else                      mac_sum = sum_w[pDATA_WIDTH-1:0];
  end
`else
  always_comb begin
    mac_sum = acc_q + (tap_do * data_do);
  end
`endif

  always_comb begin
    acc_d = acc_q;
    if (mac_reset)   acc_d = '0;
    else if (mac_en) acc_d = mac_sum;
  end

  assign hs      = tvalid_q & sm.sm_tready;
  assign push    = result_ready & (~fifo_full | hs);
  assign ovf_set = result_ready & fifo_full & ~hs;

  fir_out_fifo #(
    .WIDTH (pDATA_WIDTH),
    .DEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk     (axis_clk),
    .rst     (axis_rst),
    .push_i  (push),
    .din_i   (acc_q),
    .pop_i   (hs),
    .head_o  (head),
    .next_o  (next_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The output register always mirrors the FIFO head as it will be after this
  // edge, so an empty-FIFO push reaches sm_tdata with one cycle of latency.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (hs) begin
      if (fifo_count >= CW'(2)) begin
        tdata_d  = next_entry;
        tvalid_d = 1'b1;
      end else if (push) begin
        tdata_d  = acc_q;
        tvalid_d = 1'b1;
      end else begin
        tvalid_d = 1'b0;
      end
    end else if (fifo_empty && push) begin
      tdata_d  = acc_q;
      tvalid_d = 1'b1;
    end else if (!fifo_empty) begin
      tdata_d  = head;
      tvalid_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (hs) cnt_d = tlast_q ? '0 : cnt_q + 1'b1;

    len_d    = (cnt_q == '0 && fifo_empty) ? data_length : len_q;
    last_idx = (len_d == '0) ? '0 : len_d - 1'b1;
    tlast_d  = tvalid_d & (cnt_d == last_idx);
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      acc_q        <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      cnt_q        <= '0;
      len_q        <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      frame_done_q <= hs & tlast_q;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign sm.sm_tvalid = tvalid_q;
  assign sm.sm_tdata  = tdata_q;
  assign sm.sm_tlast  = tlast_q;
  assign res_full     = fifo_full;
  assign frame_done   = frame_done_q;
  assign ovf_err      = ovf_q;
endmodule

// File: tb/tb_fir_mac_stream_out.sv
// Directed bench for fir_mac_stream_out: MAC, priority, backpressure, framing, overflow, reset.
module tb_fir_mac_stream_out;
  logic        clk = 1'b0;
  logic        rst, mac_reset, mac_en, result_ready;
  logic [31:0] tap, data;
  logic [9:0]  data_length;
  logic        res_full, frame_done, ovf_err;
  logic [31:0] ovf_exp;
  int          n_assert = 0;
  int          n_fail   = 0;

  fir_mac_stream_out_if #(.DW(32)) sm_if ();

  fir_mac_stream_out #(
    .pDATA_WIDTH (32),
    .pFIFO_DEPTH (2),
    .pLEN_WIDTH  (10)
  ) dut (
    .axis_clk     (clk),
    .axis_rst     (rst),
    .mac_reset    (mac_reset),
    .mac_en       (mac_en),
    .tap_do       (tap),
    .data_do      (data),
    .result_ready (result_ready),
    .data_length  (data_length),
    .res_full     (res_full),
    .sm           (sm_if.master),
    .frame_done   (frame_done),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mac_reset = 1'b0; mac_en = 1'b0; result_ready = 1'b0;
    tap = '0; data = '0; data_length = 10'd1; sm_if.sm_tready = 1'b0;
`ifdef FIR_SATURATE_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = 32'h0000_0002;
`endif
    step(); step();
    chk("rst_tvalid", 32'(sm_if.sm_tvalid), 32'd0);
    chk("rst_tdata", sm_if.sm_tdata, 32'd0);
    chk("rst_tlast", 32'(sm_if.sm_tlast), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_full", 32'(res_full), 32'd0);
    rst = 1'b0;

    // 1: sum of (i+1)*2, i=0..10 = 132
    mac_reset = 1'b1; step(); mac_reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      mac_en = 1'b1; tap = 32'(i + 1); data = 32'd2; step();
    end
    mac_en = 1'b0; result_ready = 1'b1; step(); result_ready = 1'b0;
    chk("t1_tvalid", 32'(sm_if.sm_tvalid), 32'd1);
    chk("t1_tdata", sm_if.sm_tdata, 32'd132);
    chk("t1_tlast", 32'(sm_if.sm_tlast), 32'd1);
    step();
    chk("t1_stall_tdata", sm_if.sm_tdata, 32'd132);
    sm_if.sm_tready = 1'b1; step();
    chk("t1_drained", 32'(sm_if.sm_tvalid), 32'd0);
    chk("t1_frame_done", 32'(frame_done), 32'd1);
    sm_if.sm_tready = 1'b0; step();
    chk("t1_frame_done_pulse", 32'(frame_done), 32'd0);

    // 2: mac_reset beats mac_en; same-cycle mac_en excluded from pushed value
    mac_reset = 1'b1; mac_en = 1'b1; tap = 32'd5; data = 32'd5; step();
    mac_reset = 1'b0;
    result_ready = 1'b1; tap = 32'd3; data = 32'd4; step();
    chk("t2_prio_tdata", sm_if.sm_tdata, 32'd0);
    chk("t2_prio_tvalid", 32'(sm_if.sm_tvalid), 32'd1);
    mac_en = 1'b1; tap = 32'd10; data = 32'd10; sm_if.sm_tready = 1'b1; step();
    chk("t2_excl_tdata", sm_if.sm_tdata, 32'd12);
    chk("t2_excl_tvalid", 32'(sm_if.sm_tvalid), 32'd1);
    result_ready = 1'b0; mac_en = 1'b0; step();
    chk("t2_drained", 32'(sm_if.sm_tvalid), 32'd0);
    sm_if.sm_tready = 1'b0;

    // 3: backpressure with 10, 20, 30
    mac_reset = 1'b1; step(); mac_reset = 1'b0;
    mac_en = 1'b1; tap = 32'd10; data = 32'd1; step();
    result_ready = 1'b1; step();
    chk("t3_first_tdata", sm_if.sm_tdata, 32'd10);
    chk("t3_full_after1", 32'(res_full), 32'd0);
    step();
    chk("t3_full_after2", 32'(res_full), 32'd1);
    chk("t3_ovf_before", 32'(ovf_err), 32'd0);
    mac_en = 1'b0; step(); result_ready = 1'b0;
    chk("t3_ovf_set", 32'(ovf_err), 32'd1);
    chk("t3_full_kept", 32'(res_full), 32'd1);
    chk("t3_stall_tdata", sm_if.sm_tdata, 32'd10);
    step();
    chk("t3_stall_tdata2", sm_if.sm_tdata, 32'd10);
    sm_if.sm_tready = 1'b1; step();
    chk("t3_beat2_tdata", sm_if.sm_tdata, 32'd20);
    chk("t3_beat2_tvalid", 32'(sm_if.sm_tvalid), 32'd1);
    chk("t3_full_released", 32'(res_full), 32'd0);
    step();
    chk("t3_no_beat3", 32'(sm_if.sm_tvalid), 32'd0);
    chk("t3_ovf_sticky", 32'(ovf_err), 32'd1);

    // 4: frame of four
    data_length = 10'd4;
    mac_reset = 1'b1; step(); mac_reset = 1'b0;
    mac_en = 1'b1; tap = 32'd1; data = 32'd1; step();
    for (int k = 1; k <= 4; k++) begin
      result_ready = 1'b1; step();
      chk("t4_tdata", sm_if.sm_tdata, 32'(k));
      chk("t4_tlast", 32'(sm_if.sm_tlast), (k == 4) ? 32'd1 : 32'd0);
      chk("t4_no_done", 32'(frame_done), 32'd0);
    end
    result_ready = 1'b0; mac_en = 1'b0; step();
    chk("t4_frame_done", 32'(frame_done), 32'd1);
    chk("t4_drained", 32'(sm_if.sm_tvalid), 32'd0);
    step();
    chk("t4_frame_done_once", 32'(frame_done), 32'd0);

    // 5: arithmetic overflow
    sm_if.sm_tready = 1'b0;
    mac_reset = 1'b1; step(); mac_reset = 1'b0;
    mac_en = 1'b1; tap = 32'h7FFF_FFFF; data = 32'h7FFF_FFFF; step(); step();
    mac_en = 1'b0; result_ready = 1'b1; step(); result_ready = 1'b0;
    chk("t5_ovf_tdata", sm_if.sm_tdata, ovf_exp);
    chk("t5_first_not_last", 32'(sm_if.sm_tlast), 32'd0);
    sm_if.sm_tready = 1'b1; step();
    chk("t5_drained", 32'(sm_if.sm_tvalid), 32'd0);

    // 6: reset mid-frame at sample 2 with a beat pending
    result_ready = 1'b1; step(); result_ready = 1'b0;
    chk("t6_beat2_tvalid", 32'(sm_if.sm_tvalid), 32'd1);
    step();
    sm_if.sm_tready = 1'b0; result_ready = 1'b1; step(); result_ready = 1'b0;
    chk("t6_pending_tvalid", 32'(sm_if.sm_tvalid), 32'd1);
    chk("t6_pending_tlast", 32'(sm_if.sm_tlast), 32'd0);
    rst = 1'b1; data_length = 10'd2; step();
    chk("t6_rst_tvalid", 32'(sm_if.sm_tvalid), 32'd0);
    chk("t6_rst_full", 32'(res_full), 32'd0);
    chk("t6_rst_ovf", 32'(ovf_err), 32'd0);
    chk("t6_rst_tlast", 32'(sm_if.sm_tlast), 32'd0);
    rst = 1'b0;
    mac_en = 1'b1; tap = 32'd3; data = 32'd3; step();
    mac_en = 1'b0; result_ready = 1'b1; step();
    chk("t6_new_tdata", sm_if.sm_tdata, 32'd9);
    chk("t6_new_first_not_last", 32'(sm_if.sm_tlast), 32'd0);
    sm_if.sm_tready = 1'b1; step(); result_ready = 1'b0;
    chk("t6_new_second_tdata", sm_if.sm_tdata, 32'd9);
    chk("t6_new_second_last", 32'(sm_if.sm_tlast), 32'd1);
    step();
    chk("t6_new_frame_done", 32'(frame_done), 32'd1);
    chk("t6_new_drained", 32'(sm_if.sm_tvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
